// File: rtl/spm_burst.sv
// spm_burst: byte-lane scratchpad memory with a command/response handshake.
// Supports single accesses and fixed-length (BURST_LEN) read/write bursts.
// Each lane is an independent synchronous byte array; reads have one cycle
// of latency and burst responses are issued back to back without bubbles.
module spm_burst #(
    parameter int ADDR_WIDTH = 8,
    parameter int BYTES      = 4,
    parameter int BURST_LEN  = 4
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic [1:0]              io_M_Cmd,
    input  logic                    io_M_Burst,
    input  logic [ADDR_WIDTH-1:0]   io_M_Addr,
    input  logic [8*BYTES-1:0]      io_M_Data,
    input  logic [BYTES-1:0]        io_M_ByteEn,
    input  logic                    io_M_DataValid,
    output logic                    io_S_CmdAccept,
    output logic                    io_S_DataAccept,
    output logic [1:0]              io_S_Resp,
    output logic [8*BYTES-1:0]      io_S_Data
);

    localparam int DEPTH = 1 << ADDR_WIDTH;
    localparam int CW    = (BURST_LEN > 1) ? $clog2(BURST_LEN) : 1;

    localparam logic [1:0] S_IDLE     = 2'd0;
    localparam logic [1:0] S_WR_BURST = 2'd1;
    localparam logic [1:0] S_RD_BURST = 2'd2;

    localparam logic [1:0] CMD_WR    = 2'd1;
    localparam logic [1:0] CMD_RD    = 2'd2;
    localparam logic [1:0] RESP_NULL = 2'd0;
    localparam logic [1:0] RESP_DVA  = 2'd1;

    logic [1:0]            state;
    logic [CW-1:0]         cnt;
    logic [ADDR_WIDTH-1:0] addr;

    // Response pipeline: a response is due next cycle, and whether it carries read data.
    logic                  resp_vld_p1;
    logic                  rd_sel_p1;

    logic                  idle;
    logic                  cmd_wr;
    logic                  cmd_rd;
    logic                  last_beat;
    logic                  wr_en;
    logic                  rd_en;
    logic [ADDR_WIDTH-1:0] acc_addr;

    // Command decode: commands are only taken in IDLE and never while reset is held.
    always_comb begin
        idle      = (state == S_IDLE);
        cmd_wr    = idle && reset && (io_M_Cmd == CMD_WR);
        cmd_rd    = idle && reset && (io_M_Cmd == CMD_RD);
        last_beat = (cnt == CW'(BURST_LEN - 1));
        wr_en     = cmd_wr || ((state == S_WR_BURST) && io_M_DataValid);
        rd_en     = cmd_rd || (state == S_RD_BURST);
        acc_addr  = idle ? io_M_Addr : addr;
    end

    assign io_S_CmdAccept  = idle;
    assign io_S_DataAccept = (state == S_WR_BURST);
    assign io_S_Resp       = resp_vld_p1 ? RESP_DVA : RESP_NULL;

    // Sequencer: burst state, beat counter, running address and response flags.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state       <= S_IDLE;
            cnt         <= '0;
            addr        <= '0;
            resp_vld_p1 <= 1'b0;
            rd_sel_p1   <= 1'b0;
        end else begin
            resp_vld_p1 <= 1'b0;
            rd_sel_p1   <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (cmd_wr || cmd_rd) begin
                        // A burst write answers only after its final beat.
                        resp_vld_p1 <= cmd_rd || !io_M_Burst;
                        rd_sel_p1   <= cmd_rd;
                        if (io_M_Burst) begin
                            state <= cmd_wr ? S_WR_BURST : S_RD_BURST;
                            addr  <= io_M_Addr + ADDR_WIDTH'(1);
                            cnt   <= CW'(1);
                        end
                    end
                end
                S_WR_BURST: begin
                    if (io_M_DataValid) begin
                        addr <= addr + ADDR_WIDTH'(1);
                        cnt  <= cnt + CW'(1);
                        if (last_beat) begin
                            state       <= S_IDLE;
                            cnt         <= '0;
                            resp_vld_p1 <= 1'b1;
                        end
                    end
                end
                S_RD_BURST: begin
                    resp_vld_p1 <= 1'b1;
                    rd_sel_p1   <= 1'b1;
                    addr        <= addr + ADDR_WIDTH'(1);
                    cnt         <= cnt + CW'(1);
                    if (last_beat) begin
                        state <= S_IDLE;
                        cnt   <= '0;
                    end
                end
                default: begin
                    state <= S_IDLE;
                    cnt   <= '0;
                end
            endcase
        end
    end

    for (genvar i = 0; i < BYTES; i++) begin : g_lane
        logic [7:0] mem [DEPTH];
        logic [7:0] rdata_p1;

        // Lane storage: byte-enabled write and registered read, contents never reset.
        always_ff @(posedge clk) begin
            if (wr_en && io_M_ByteEn[i]) begin
                mem[acc_addr] <= io_M_Data[8*i +: 8];
            end
            if (rd_en) begin
                rdata_p1 <= mem[acc_addr];
            end
        end

        assign io_S_Data[8*i +: 8] = rd_sel_p1 ? rdata_p1 : 8'h00;
    end

endmodule
